// File: rtl/oled_spi_receiver.sv
// SSD1331-side SPI receiver: oversamples the 4-wire link, assembles bytes, decodes window/display commands, emits pixel writes.
// Optional framing-error counter enabled by defining OLED_RX_ERR_CNT_EN.
module oled_spi_receiver #(
    parameter int          NUM_COL      = 96,
    parameter int          NUM_ROW      = 64,
    parameter int          N_COLOR_BITS = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                       i_CLK,
    input  logic                       i_RST_N,
    input  logic                       i_CS,
    input  logic                       i_MOSI,
    input  logic                       i_SCK,
    input  logic                       i_DC,
    input  logic                       i_RES,
    output logic [7:0]                 o_BYTE,
    output logic                       o_BYTE_DC,
    output logic                       o_BYTE_VALID,
    output logic                       o_PIX_WE,
    output logic [$clog2(NUM_COL)-1:0] o_PIX_COL,
    output logic [$clog2(NUM_ROW)-1:0] o_PIX_ROW,
    output logic [N_COLOR_BITS-1:0]    o_PIX_DATA,
    output logic                       o_DISPLAY_ON,
    output logic [7:0]                 o_ERR_CNT
);
    localparam int CW = $clog2(NUM_COL);
    localparam int RW = $clog2(NUM_ROW);
    localparam logic [7:0] COL_MAX = 8'(NUM_COL - 1);
    localparam logic [7:0] ROW_MAX = 8'(NUM_ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARG0, S_ARG1, S_SKIP} state_t;

    // Pin vector {RES, DC, SCK, MOSI, CS}; idle-high pins reset to 1 so no false edge after reset
    logic [4:0] r_sync [SYNC_STAGES];
    logic       w_cs, w_mosi, w_sck, w_dc, w_res, w_sck_rise;
    logic       r_sck_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_byte;
    logic       r_byte_dc, r_byte_valid;

    assign {w_res, w_dc, w_sck, w_mosi, w_cs} = r_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 5'b10101;
        end else begin
            r_sync[0] <= {i_RES, i_DC, i_SCK, i_MOSI, i_CS};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_sck_prev   <= 1'b1;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_byte_dc    <= 1'b0;
            r_byte_valid <= 1'b0;
        end else begin
            r_sck_prev   <= w_sck;
            r_byte_valid <= 1'b0;
            if (!w_res) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_byte    <= '0;
                r_byte_dc <= 1'b0;
            end else if (w_cs) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte       <= {r_shift, w_mosi};
                    r_byte_dc    <= w_dc;
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

`ifdef OLED_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N)
            r_err_cnt <= '0;
        else if (w_res && w_cs && (r_bit_cnt != 3'd0) && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign o_ERR_CNT = r_err_cnt;
`else
    assign o_ERR_CNT = '0;
`endif

    state_t          r_state;
    logic [7:0]      r_opcode, r_arg_start;
    logic [CW-1:0]   r_col_start, r_col_end, r_cur_col, r_pix_col;
    logic [RW-1:0]   r_row_start, r_row_end, r_cur_row, r_pix_row;
    logic [N_COLOR_BITS-1:0] r_pix_data;
    logic            r_pix_we, r_display_on;
    logic [7:0]      w_max, w_clamp, w_end;
    logic            w_one_arg;

    assign w_max   = (r_opcode == 8'h75) ? ROW_MAX : COL_MAX;
    assign w_clamp = (r_byte > w_max) ? w_max : r_byte;
    assign w_end   = (w_clamp < r_arg_start) ? r_arg_start : w_clamp;

    always_comb begin
        w_one_arg = 1'b0;
        case (r_byte)
            8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0,
            8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB1, 8'hB3, 8'hBB, 8'hBE: w_one_arg = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state      <= S_IDLE;
            r_opcode     <= '0;
            r_arg_start  <= '0;
            r_col_start  <= '0;
            r_col_end    <= COL_MAX[CW-1:0];
            r_row_start  <= '0;
            r_row_end    <= ROW_MAX[RW-1:0];
            r_cur_col    <= '0;
            r_cur_row    <= '0;
            r_display_on <= 1'b0;
            r_pix_we     <= 1'b0;
            r_pix_col    <= '0;
            r_pix_row    <= '0;
            r_pix_data   <= '0;
        end else begin
            r_pix_we <= 1'b0;
            if (!w_res) begin
                r_state      <= S_IDLE;
                r_opcode     <= '0;
                r_arg_start  <= '0;
                r_col_start  <= '0;
                r_col_end    <= COL_MAX[CW-1:0];
                r_row_start  <= '0;
                r_row_end    <= ROW_MAX[RW-1:0];
                r_cur_col    <= '0;
                r_cur_row    <= '0;
                r_display_on <= 1'b0;
            end else if (r_byte_valid) begin
                if (r_byte_dc) begin
                    // Data always writes at the pre-increment cursor and aborts any pending command
                    r_state    <= S_IDLE;
                    r_pix_we   <= 1'b1;
                    r_pix_col  <= r_cur_col;
                    r_pix_row  <= r_cur_row;
                    r_pix_data <= r_byte;
                    if (r_cur_col == r_col_end) begin
                        r_cur_col <= r_col_start;
                        r_cur_row <= (r_cur_row == r_row_end) ? r_row_start : r_cur_row + 1'b1;
                    end else begin
                        r_cur_col <= r_cur_col + 1'b1;
                    end
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (r_byte == 8'h15 || r_byte == 8'h75) begin
                                r_opcode <= r_byte;
                                r_state  <= S_ARG0;
                            end else if (r_byte == 8'hAF) begin
                                r_display_on <= 1'b1;
                            end else if (r_byte == 8'hAE) begin
                                r_display_on <= 1'b0;
                            end else if (w_one_arg) begin
                                r_state <= S_SKIP;
                            end
                        end
                        S_ARG0: begin
                            r_arg_start <= w_clamp;
                            r_state     <= S_ARG1;
                        end
                        S_ARG1: begin
                            if (r_opcode == 8'h15) begin
                                r_col_start <= r_arg_start[CW-1:0];
                                r_col_end   <= w_end[CW-1:0];
                                r_cur_col   <= r_arg_start[CW-1:0];
                            end else begin
                                r_row_start <= r_arg_start[RW-1:0];
                                r_row_end   <= w_end[RW-1:0];
                                r_cur_row   <= r_arg_start[RW-1:0];
                            end
                            r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_BYTE       = r_byte;
    assign o_BYTE_DC    = r_byte_dc;
    assign o_BYTE_VALID = r_byte_valid;
    assign o_PIX_WE     = r_pix_we;
    assign o_PIX_COL    = r_pix_col;
    assign o_PIX_ROW    = r_pix_row;
    assign o_PIX_DATA   = r_pix_data;
    assign o_DISPLAY_ON = r_display_on;
endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: drives the SPI pins and checks bytes, pixel writes, window and display state.
module tb_oled_spi_receiver;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cs = 1'b1, mosi = 1'b0, sck = 1'b1, dc = 1'b0, res = 1'b1;
    logic [7:0] byte_o, err_cnt;
    logic       byte_dc, byte_valid, pix_we, disp_on;
    logic [6:0] pix_col;
    logic [5:0] pix_row;
    logic [7:0] pix_data;

    int checks = 0, failures = 0;
    int n_valid = 0, n_pix = 0;
    int log_col [256], log_row [256], log_data [256];
    time t_valid = 0, t_pix = 0, t_rise = 0;
    int exp_err;

    oled_spi_receiver #(.NUM_COL(96), .NUM_ROW(64), .N_COLOR_BITS(8), .SYNC_STAGES(2)) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_CS(cs), .i_MOSI(mosi), .i_SCK(sck), .i_DC(dc), .i_RES(res),
        .o_BYTE(byte_o), .o_BYTE_DC(byte_dc), .o_BYTE_VALID(byte_valid), .o_PIX_WE(pix_we),
        .o_PIX_COL(pix_col), .o_PIX_ROW(pix_row), .o_PIX_DATA(pix_data),
        .o_DISPLAY_ON(disp_on), .o_ERR_CNT(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_valid++;
            t_valid = $time;
        end
        if (pix_we && n_pix < 256) begin
            log_col[n_pix]  = int'(pix_col);
            log_row[n_pix]  = int'(pix_row);
            log_data[n_pix] = int'(pix_data);
            n_pix++;
            t_pix = $time;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic d, input logic [7:0] b, input int n);
        dc = d;
        cs = 1'b0;
        #40;
        for (int i = 0; i < n; i++) begin
            sck  = 1'b0;
            mosi = b[7-i];
            #40;
            sck    = 1'b1;
            t_rise = $time;
            #40;
        end
        cs = 1'b1;
        #40;
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        send_bits(d, b, 8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        #20;
    endtask

    task automatic check_pix(input string tag, input int idx, input int c, input int r, input int d);
        check({tag, "_col"}, log_col[idx], c);
        check({tag, "_row"}, log_row[idx], r);
        check({tag, "_data"}, log_data[idx], d);
    endtask

    initial begin
        int base, v0;
        int exp_c [7] = '{2, 3, 4, 2, 3, 4, 2};
        int exp_r [7] = '{1, 1, 1, 2, 2, 2, 1};
`ifdef OLED_RX_ERR_CNT_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        #20;
        check("rst_byte", int'(byte_o), 0);
        check("rst_valid", int'(byte_valid), 0);
        check("rst_pix_we", int'(pix_we), 0);
        check("rst_disp", int'(disp_on), 0);
        check("rst_err", int'(err_cnt), 0);
        rst_n = 1'b1;
        #20;

        // Display on/off and byte latency
        send_byte(1'b0, 8'hAF);
        check("cmd_byte", int'(byte_o), 'hAF);
        check("cmd_dc", int'(byte_dc), 0);
        check("disp_on", int'(disp_on), 1);
        check("valid_latency", int'(t_valid - t_rise), 30);
        send_byte(1'b0, 8'hAE);
        check("disp_off", int'(disp_on), 0);

        // Window 2..4 x 1..2 with wrap
        send_byte(1'b0, 8'h15); send_byte(1'b0, 8'd2); send_byte(1'b0, 8'd4);
        send_byte(1'b0, 8'h75); send_byte(1'b0, 8'd1); send_byte(1'b0, 8'd2);
        base = n_pix;
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'(8'h10 + i));
        check("win_pix_count", n_pix - base, 7);
        check("data_dc", int'(byte_dc), 1);
        check("pix_latency", int'(t_pix - t_valid), 10);
        for (int i = 0; i < 7; i++) check_pix($sformatf("win%0d", i), base + i, exp_c[i], exp_r[i], 'h10 + i);

        // Framing error then a clean byte
        do_reset();
        v0 = n_valid;
        send_bits(1'b0, 8'hFF, 5);
        send_byte(1'b0, 8'hA5);
        check("frame_valid_count", n_valid - v0, 1);
        check("frame_byte", int'(byte_o), 'hA5);
        check("frame_err", int'(err_cnt), exp_err);

        // One-argument command swallows the next command byte
        do_reset();
        base = n_pix;
        send_byte(1'b0, 8'hA0); send_byte(1'b0, 8'h15); send_byte(1'b1, 8'h3C);
        check("skip_pix_count", n_pix - base, 1);
        check_pix("skip", base, 0, 0, 'h3C);

        // Clamp: start 200 -> 95, end 10 < start -> 95
        base = n_pix;
        send_byte(1'b0, 8'h15); send_byte(1'b0, 8'd200); send_byte(1'b0, 8'd10);
        send_byte(1'b1, 8'hC1); send_byte(1'b1, 8'hC2);
        check_pix("clamp0", base, 95, 0, 'hC1);
        check_pix("clamp1", base + 1, 95, 1, 'hC2);

        // OLED reset pin restores full window, clears display, keeps error count
        send_byte(1'b0, 8'hAF);
        check("res_disp_pre", int'(disp_on), 1);
        send_bits(1'b0, 8'h00, 3);
        check("res_err_pre", int'(err_cnt), exp_err);
        res = 1'b0;
        #60;
        res = 1'b1;
        #60;
        check("res_disp", int'(disp_on), 0);
        check("res_err", int'(err_cnt), exp_err);
        base = n_pix;
        send_byte(1'b1, 8'h55); send_byte(1'b1, 8'h66);
        check_pix("res0", base, 0, 0, 'h55);
        check_pix("res1", base + 1, 1, 0, 'h66);

        // Data byte aborts a pending window command
        send_byte(1'b0, 8'h15); send_byte(1'b1, 8'h77); send_byte(1'b1, 8'h78);
        check_pix("abort0", base + 2, 2, 0, 'h77);
        check_pix("abort1", base + 3, 3, 0, 'h78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
